uart_rx_frame_ctrl: RTL

//  Frame controller behind uart_rx. Consumes the byte stream (rx_byte/byte_valid), parses

---
 rtl/uart_rx_frame_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC|ADDR|LEN|DATA[LEN]|CHK frames and replays the payload as register writes.
// Build option: define UART_RX_FRAME_CHK_EN to require and verify the trailing CHK byte.
module uart_rx_frame_ctrl #(
  parameter int         word_width   = 8,
  parameter int         max_len      = 16,
  parameter int         timeout_clks = 100_000,
  parameter logic [7:0] sync_byte    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] rx_byte,
  input  logic                  byte_valid,
  output logic                  wr_en,
  output logic [7:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [2:0]            err_code,
  output logic                  busy
);

  localparam int AW = (max_len > 1) ? $clog2(max_len) : 1;
  localparam int TW = (timeout_clks > 2) ? $clog2(timeout_clks) : 2;
  localparam logic [7:0]    MAX_LEN_B = 8'(max_len);
  localparam logic [TW-1:0] TMO_LAST  = TW'(timeout_clks - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_LEN  = 3'd1,
    ERR_CHK  = 3'd2,
    ERR_OVR  = 3'd3,
    ERR_TMO  = 3'd4
  } err_t;

  state_t        state, state_nxt;
  logic [7:0]    base, base_nxt;
  logic [7:0]    len, len_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [7:0]    cidx, cidx_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          ovr_pend, ovr_nxt;
  logic          buf_we;
  logic          start_commit;
  logic          tmo_active;
  logic          wr_en_nxt;
  logic [7:0]    wr_addr_nxt;
  logic [7:0]    wr_data_nxt;
  logic          done_nxt;
  logic          err_nxt;
  logic [2:0]    code_nxt;
  logic          busy_nxt;
  logic [7:0]    first_data;
`ifdef UART_RX_FRAME_CHK_EN
  logic [7:0]    chk, chk_nxt;
`endif

  logic [7:0] payload_mem [0:max_len-1];

  // Payload buffer has no reset; only indices below the latched length are ever read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      payload_mem[idx[AW-1:0]] <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      cidx       <= '0;
      tmo_cnt    <= '0;
      ovr_pend   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      busy       <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
      chk        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      len        <= len_nxt;
      idx        <= idx_nxt;
      cidx       <= cidx_nxt;
      tmo_cnt    <= tmo_nxt;
      ovr_pend   <= ovr_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      err_code   <= code_nxt;
      busy       <= busy_nxt;
`ifdef UART_RX_FRAME_CHK_EN
      chk        <= chk_nxt;
`endif
    end
  end

  assign tmo_active = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CHK);

  // Without a CHK byte the first write can be the byte arriving right now.
  assign first_data = ((state == S_DATA) && (idx == 8'd0)) ? rx_byte : payload_mem[0];

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    len_nxt      = len;
    idx_nxt      = idx;
    cidx_nxt     = cidx;
    tmo_nxt      = '0;
    ovr_nxt      = ovr_pend;
    buf_we       = 1'b0;
    start_commit = 1'b0;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    code_nxt     = err_code;
`ifdef UART_RX_FRAME_CHK_EN
    chk_nxt      = chk;
`endif

    unique case (state)
      S_IDLE: begin
        // An overrun caught on the final commit cycle is reported here so it never meets frame_done.
        if (ovr_pend) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_OVR;
          ovr_nxt  = 1'b0;
        end
        if (byte_valid && (rx_byte == sync_byte)) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (byte_valid) begin
          base_nxt  = rx_byte;
`ifdef UART_RX_FRAME_CHK_EN
          chk_nxt   = rx_byte;
`endif
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_valid) begin
          if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_LEN;
            state_nxt = S_IDLE;
          end else begin
            len_nxt   = rx_byte;
            idx_nxt   = 8'd0;
`ifdef UART_RX_FRAME_CHK_EN
            chk_nxt   = chk ^ rx_byte;
`endif
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_valid) begin
          buf_we  = 1'b1;
          idx_nxt = idx + 8'd1;
`ifdef UART_RX_FRAME_CHK_EN
          chk_nxt = chk ^ rx_byte;
          if (idx == (len - 8'd1)) begin
            state_nxt = S_CHK;
          end
`else
          if (idx == (len - 8'd1)) begin
            start_commit = 1'b1;
          end
`endif
        end
      end
`ifdef UART_RX_FRAME_CHK_EN
      S_CHK: begin
        if (byte_valid) begin
          if (rx_byte == chk) begin
            start_commit = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_CHK;
            state_nxt = S_IDLE;
          end
        end
      end
`endif
      S_COMMIT: begin
        if (byte_valid) begin
          if (cidx == len) begin
            ovr_nxt = 1'b1;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = ERR_OVR;
          end
        end
        if (cidx == len) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = base + cidx;
          wr_data_nxt = payload_mem[cidx[AW-1:0]];
          cidx_nxt    = cidx + 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (start_commit) begin
      state_nxt   = S_COMMIT;
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = base;
      wr_data_nxt = first_data;
      cidx_nxt    = 8'd1;
    end

    // A byte arriving on the expiry cycle wins: the counter simply restarts.
    if (tmo_active && !byte_valid) begin
      if (tmo_cnt == TMO_LAST) begin
        err_nxt   = 1'b1;
        code_nxt  = ERR_TMO;
        state_nxt = S_IDLE;
      end else begin
        tmo_nxt = tmo_cnt + TW'(1);
      end
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
